// File: rtl/csr_port_arbiter.sv
// Arbiter for the machine CSR file port, shared by the pipeline (id 0) and debug (id 1).
// Each accepted request runs as a read-modify-write, with privilege and read-only checks done at accept.
module csr_port_arbiter #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [2*ADDR_W-1:0]   req_addr_i,
  input  logic [3:0]            req_op_i,
  input  logic [2*XLEN-1:0]     req_wdata_i,
  input  logic [1:0]            req_priv_i,
  input  logic                  flush_i,
  output logic                  csr_re_o,
  output logic [ADDR_W-1:0]     csr_raddr_o,
  input  logic [XLEN-1:0]       csr_rdata_i,
  input  logic                  csr_rerr_i,
  output logic                  csr_we_o,
  output logic [ADDR_W-1:0]     csr_waddr_o,
  output logic [XLEN-1:0]       csr_wdata_o,
  output logic                  rsp_valid_o,
  output logic                  rsp_id_o,
  output logic [XLEN-1:0]       rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [1:0]        state;
  logic              last_grant;
  logic              lat_id;
  logic [ADDR_W-1:0] lat_addr;
  logic [1:0]        lat_op;
  logic [XLEN-1:0]   lat_wdata;

  logic              grant;
  logic              grant_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_op;
  logic [XLEN-1:0]   sel_wdata;
  logic [1:0]        sel_priv;
  logic              sel_writes;
  logic              sel_fault;

  logic              lat_writes;
  logic              kill;
  logic              in_rd;
  logic              in_wr;
  logic              in_err;
  logic [XLEN-1:0]   new_val;

  // Round-robin: on a tie the requester that was not granted last wins.
  always_comb begin
    grant    = 1'b0;
    grant_id = 1'b0;
    if (state == S_IDLE && !reset) begin
      case (req_valid_i)
        2'b01:   begin grant = 1'b1; grant_id = 1'b0;        end
        2'b10:   begin grant = 1'b1; grant_id = 1'b1;        end
        2'b11:   begin grant = 1'b1; grant_id = ~last_grant; end
        default: begin grant = 1'b0; grant_id = 1'b0;        end
      endcase
    end
  end

  always_comb begin
    sel_addr   = grant_id ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
    sel_op     = grant_id ? req_op_i[3:2] : req_op_i[1:0];
    sel_wdata  = grant_id ? req_wdata_i[2*XLEN-1:XLEN] : req_wdata_i[XLEN-1:0];
    sel_priv   = grant_id ? 2'b11 : req_priv_i;
    sel_writes = (sel_op == OP_WRITE) || (sel_op[1] && (sel_wdata != '0));
    sel_fault  = (sel_priv < sel_addr[9:8]) ||
                 ((sel_addr[11:10] == 2'b11) && sel_writes);
  end

  assign req_ready_o = grant ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      lat_id     <= 1'b0;
      lat_addr   <= '0;
      lat_op     <= '0;
      lat_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            last_grant <= grant_id;
            lat_id     <= grant_id;
            lat_addr   <= sel_addr;
            lat_op     <= sel_op;
            lat_wdata  <= sel_wdata;
            state      <= sel_fault ? S_ERR : S_RD;
          end
        end
        S_RD:    state <= kill ? S_IDLE : S_WR;
        S_WR:    state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // A pipeline flush only matters once a pipeline request is in flight.
  assign kill       = flush_i && !lat_id;
  assign lat_writes = (lat_op == OP_WRITE) || (lat_op[1] && (lat_wdata != '0));
  assign in_rd      = (state == S_RD)  && !reset;
  assign in_wr      = (state == S_WR)  && !reset;
  assign in_err     = (state == S_ERR) && !reset;

  always_comb begin
    case (lat_op)
      OP_WRITE: new_val = lat_wdata;
      OP_SET:   new_val = csr_rdata_i | lat_wdata;
      OP_CLEAR: new_val = csr_rdata_i & ~lat_wdata;
      default:  new_val = csr_rdata_i;
    endcase
  end

  assign csr_re_o    = in_rd;
  assign csr_raddr_o = lat_addr;
  assign csr_we_o    = in_wr && lat_writes && !csr_rerr_i && !kill;
  assign csr_waddr_o = lat_addr;
  assign csr_wdata_o = in_wr ? new_val : '0;
  assign rsp_valid_o = (in_wr || in_err) && !kill;
  assign rsp_id_o    = lat_id;
  assign rsp_rdata_o = in_wr ? csr_rdata_i : '0;
  assign rsp_err_o   = in_err || (in_wr && csr_rerr_i);

endmodule

// File: tb/tb_csr_port_arbiter.sv
// Self-checking bench for csr_port_arbiter: a CSR-file model answers reads, and
// expected responses/writes are queued at accept and compared when the DUT emits them.
module tb_csr_port_arbiter;
  localparam int XLEN   = 64;
  localparam int ADDR_W = 12;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          req_valid_i;
  logic [1:0]          req_ready_o;
  logic [2*ADDR_W-1:0] req_addr_i;
  logic [3:0]          req_op_i;
  logic [2*XLEN-1:0]   req_wdata_i;
  logic [1:0]          req_priv_i;
  logic                flush_i;
  logic                csr_re_o;
  logic [ADDR_W-1:0]   csr_raddr_o;
  logic [XLEN-1:0]     csr_rdata_i;
  logic                csr_rerr_i;
  logic                csr_we_o;
  logic [ADDR_W-1:0]   csr_waddr_o;
  logic [XLEN-1:0]     csr_wdata_o;
  logic                rsp_valid_o;
  logic                rsp_id_o;
  logic [XLEN-1:0]     rsp_rdata_o;
  logic                rsp_err_o;

  always #5 clk = ~clk;

  csr_port_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_op_i(req_op_i), .req_wdata_i(req_wdata_i),
    .req_priv_i(req_priv_i), .flush_i(flush_i),
    .csr_re_o(csr_re_o), .csr_raddr_o(csr_raddr_o),
    .csr_rdata_i(csr_rdata_i), .csr_rerr_i(csr_rerr_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
  );

  typedef struct packed {
    logic            id;
    logic [XLEN-1:0] rdata;
    logic            err;
  } rsp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  int unsigned vectors;
  int unsigned miscompares;
  logic [XLEN-1:0] mem [bit [ADDR_W-1:0]];
  logic [ADDR_W-1:0] bad_addr;

  function automatic logic [XLEN-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  // CSR file model: read data and error arrive the cycle after the read strobe.
  task automatic responder();
    logic rp, wp;
    logic [ADDR_W-1:0] ra, wa;
    logic [XLEN-1:0] wd;
    forever begin
      @(negedge clk);
      rp = (csr_re_o === 1'b1); ra = csr_raddr_o;
      wp = (csr_we_o === 1'b1); wa = csr_waddr_o; wd = csr_wdata_o;
      @(posedge clk); #1;
      if (wp) mem[wa] = wd;
      csr_rerr_i  = rp && (ra == bad_addr);
      csr_rdata_i = (rp && ra != bad_addr) ? mem_rd(ra) : '0;
    end
  endtask

  task automatic monitor();
    rsp_t got_r, exp_r;
    wr_t  got_w, exp_w;
    forever begin
      @(negedge clk);
      if (rsp_valid_o === 1'b1) begin
        vectors++;
        got_r = {rsp_id_o, rsp_rdata_o, rsp_err_o};
        if (rsp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_unexpected: got id=%0d rdata=%h err=%0d, required no response",
                   got_r.id, got_r.rdata, got_r.err);
        end else begin
          exp_r = rsp_q.pop_front();
          if (got_r !== exp_r) begin
            miscompares++;
            $display("FAIL rsp_content: got id=%0d rdata=%h err=%0d, required id=%0d rdata=%h err=%0d",
                     got_r.id, got_r.rdata, got_r.err, exp_r.id, exp_r.rdata, exp_r.err);
          end
        end
      end
      if (csr_we_o === 1'b1) begin
        vectors++;
        got_w = {csr_waddr_o, csr_wdata_o};
        if (wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL write_unexpected: got addr=%h data=%h, required no write",
                   got_w.addr, got_w.data);
        end else begin
          exp_w = wr_q.pop_front();
          if (got_w !== exp_w) begin
            miscompares++;
            $display("FAIL write_content: got addr=%h data=%h, required addr=%h data=%h",
                     got_w.addr, got_w.data, exp_w.addr, exp_w.data);
          end
        end
      end
    end
  endtask

  // Presents one request and returns just after the posedge ending the accept cycle.
  task automatic drive_req(input logic id, input logic [ADDR_W-1:0] addr, input logic [1:0] op,
                           input logic [XLEN-1:0] wd, input logic [1:0] priv, output int waits);
    @(posedge clk); #1;
    flush_i = 1'b0;
    req_addr_i[id*ADDR_W +: ADDR_W] = addr;
    req_op_i[id*2 +: 2]             = op;
    req_wdata_i[id*XLEN +: XLEN]    = wd;
    if (!id) req_priv_i = priv;
    req_valid_i[id] = 1'b1;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (req_ready_o[id] !== 1'b1 && waits < 20);
    if (req_ready_o[id] !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: got ready=%b after %0d cycles, required ready[%0d]=1",
               req_ready_o, waits, id);
    end
    @(posedge clk); #1;
    req_valid_i[id] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush_i = 1'b0;
    req_valid_i = 2'b11; req_addr_i = {12'h300, 12'h300}; req_op_i = 4'b0000;
    req_wdata_i = '0; req_priv_i = 2'b11;
    repeat (2) @(negedge clk);
    vectors++;
    if (req_ready_o !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, required 00", req_ready_o);
    end
    vectors++;
    if ({csr_re_o, csr_we_o, rsp_valid_o, rsp_id_o, rsp_err_o} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: got re=%b we=%b vld=%b id=%b err=%b, required all 0",
               csr_re_o, csr_we_o, rsp_valid_o, rsp_id_o, rsp_err_o);
    end
    vectors++;
    if ({csr_raddr_o, csr_waddr_o, csr_wdata_o, rsp_rdata_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got raddr=%h waddr=%h wdata=%h rdata=%h, required all 0",
               csr_raddr_o, csr_waddr_o, csr_wdata_o, rsp_rdata_o);
    end
    @(posedge clk); #1;
    reset = 1'b0; req_valid_i = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    int cnt;
    logic exp_id;
    @(posedge clk); #1;
    req_addr_i  = {12'h7B0, 12'h300};
    req_op_i    = 4'b0000;
    req_wdata_i = '0;
    req_priv_i  = 2'b11;
    req_valid_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_id = k[0];
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (req_ready_o === 2'b00 && cnt < 10);
      vectors++;
      if (req_ready_o !== (exp_id ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL arb_grant%0d: got ready=%b, required %b", k, req_ready_o, exp_id ? 2'b10 : 2'b01);
      end
      vectors++;
      if (cnt !== (k == 0 ? 1 : 3)) begin
        miscompares++;
        $display("FAIL arb_spacing%0d: got %0d cycles, required %0d", k, cnt, (k == 0 ? 1 : 3));
      end
      rsp_q.push_back(rsp_t'{exp_id, mem_rd(exp_id ? 12'h7B0 : 12'h300), 1'b0});
    end
    @(posedge clk); #1;
    req_valid_i = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_csrrs();
    int w;
    mem[12'h300] = 64'h1800;
    drive_req(1'b0, 12'h300, 2'b10, 64'h8, 2'b11, w);
    rsp_q.push_back(rsp_t'{1'b0, 64'h1800, 1'b0});
    wr_q.push_back(wr_t'{12'h300, 64'h1808});
    @(negedge clk);
    vectors++;
    if ({csr_re_o, csr_raddr_o, csr_we_o} !== {1'b1, 12'h300, 1'b0}) begin
      miscompares++;
      $display("FAIL csrrs_n1: got re=%b raddr=%h we=%b, required re=1 raddr=300 we=0",
               csr_re_o, csr_raddr_o, csr_we_o);
    end
    @(negedge clk);
    vectors++;
    if ({csr_we_o, rsp_valid_o} !== 2'b11) begin
      miscompares++;
      $display("FAIL csrrs_n2: got we=%b vld=%b, required 1 1", csr_we_o, rsp_valid_o);
    end
    mem[12'h304] = 64'hFF;
    drive_req(1'b0, 12'h304, 2'b11, 64'h0F, 2'b11, w);
    rsp_q.push_back(rsp_t'{1'b0, 64'hFF, 1'b0});
    wr_q.push_back(wr_t'{12'h304, 64'hF0});
    repeat (2) @(negedge clk);
    drive_req(1'b1, 12'h7B1, 2'b01, 64'h1234, 2'b00, w);
    rsp_q.push_back(rsp_t'{1'b1, mem_rd(12'h7B1), 1'b0});
    wr_q.push_back(wr_t'{12'h7B1, 64'h1234});
    repeat (2) @(negedge clk);
  endtask

  task automatic test_priv();
    int w;
    mem[12'h341] = 64'hDEAD;
    drive_req(1'b0, 12'h341, 2'b00, 64'h0, 2'b00, w);
    rsp_q.push_back(rsp_t'{1'b0, 64'h0, 1'b1});
    @(negedge clk);
    vectors++;
    if ({rsp_valid_o, rsp_err_o, csr_re_o, csr_we_o} !== 4'b1100) begin
      miscompares++;
      $display("FAIL priv_fault_n1: got vld=%b err=%b re=%b we=%b, required 1 1 0 0",
               rsp_valid_o, rsp_err_o, csr_re_o, csr_we_o);
    end
    @(negedge clk);
    vectors++;
    if ({csr_re_o, csr_we_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL priv_fault_n2: got re=%b we=%b, required 0 0", csr_re_o, csr_we_o);
    end
    drive_req(1'b1, 12'h341, 2'b00, 64'h0, 2'b00, w);
    rsp_q.push_back(rsp_t'{1'b1, 64'hDEAD, 1'b0});
    @(negedge clk);
    vectors++;
    if (csr_re_o !== 1'b1) begin
      miscompares++;
      $display("FAIL priv_debug_read: got re=%b, required 1", csr_re_o);
    end
    @(negedge clk);
  endtask

  task automatic test_readonly();
    int w;
    mem[12'hC00] = 64'hF00D;
    drive_req(1'b0, 12'hC00, 2'b01, 64'h5, 2'b11, w);
    rsp_q.push_back(rsp_t'{1'b0, 64'h0, 1'b1});
    @(negedge clk);
    vectors++;
    if ({rsp_valid_o, csr_re_o, csr_we_o} !== 3'b100) begin
      miscompares++;
      $display("FAIL ro_write_n1: got vld=%b re=%b we=%b, required 1 0 0", rsp_valid_o, csr_re_o, csr_we_o);
    end
    drive_req(1'b0, 12'hC00, 2'b10, 64'h0, 2'b11, w);
    rsp_q.push_back(rsp_t'{1'b0, 64'hF00D, 1'b0});
    @(negedge clk);
    vectors++;
    if (csr_re_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ro_set0_read: got re=%b, required 1", csr_re_o);
    end
    @(negedge clk);
    vectors++;
    if ({csr_we_o, rsp_valid_o, rsp_err_o} !== 3'b010) begin
      miscompares++;
      $display("FAIL ro_set0_n2: got we=%b vld=%b err=%b, required 0 1 0", csr_we_o, rsp_valid_o, rsp_err_o);
    end
  endtask

  task automatic test_rerr();
    int w;
    drive_req(1'b0, 12'h7C5, 2'b01, 64'h55, 2'b11, w);
    rsp_q.push_back(rsp_t'{1'b0, 64'h0, 1'b1});
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({csr_we_o, rsp_valid_o, rsp_err_o} !== 3'b011) begin
      miscompares++;
      $display("FAIL rerr_n2: got we=%b vld=%b err=%b, required 0 1 1", csr_we_o, rsp_valid_o, rsp_err_o);
    end
  endtask

  task automatic test_flush();
    int w;
    drive_req(1'b0, 12'h340, 2'b01, 64'h77, 2'b11, w);
    flush_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (csr_re_o !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_rd_strobe: got re=%b, required 1", csr_re_o);
    end
    drive_req(1'b1, 12'h341, 2'b00, 64'h0, 2'b11, w);
    vectors++;
    if (w !== 1) begin
      miscompares++;
      $display("FAIL flush_reaccept: got accept after %0d cycles, required 1", w);
    end
    rsp_q.push_back(rsp_t'{1'b1, 64'hDEAD, 1'b0});
    repeat (2) @(negedge clk);
    drive_req(1'b1, 12'h7B2, 2'b01, 64'hAB, 2'b11, w);
    flush_i = 1'b1;
    rsp_q.push_back(rsp_t'{1'b1, mem_rd(12'h7B2), 1'b0});
    wr_q.push_back(wr_t'{12'h7B2, 64'hAB});
    repeat (2) @(negedge clk);
    vectors++;
    if ({csr_we_o, rsp_valid_o} !== 2'b11) begin
      miscompares++;
      $display("FAIL flush_debug_ignored: got we=%b vld=%b, required 1 1", csr_we_o, rsp_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    drive_req(1'b0, 12'h340, 2'b01, 64'h99, 2'b11, w);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({csr_re_o, csr_we_o, rsp_valid_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid_rd: got re=%b we=%b vld=%b, required 0 0 0", csr_re_o, csr_we_o, rsp_valid_o);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({csr_re_o, csr_we_o, rsp_valid_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid_after: got re=%b we=%b vld=%b, required 0 0 0", csr_re_o, csr_we_o, rsp_valid_o);
    end
    vectors++;
    if (mem_rd(12'h340) !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_mid_nowrite: got csr[340]=%h, required 0", mem_rd(12'h340));
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    @(posedge clk); #1;
    req_addr_i[ADDR_W-1:0] = 12'h341;
    req_op_i[1:0]          = 2'b00;
    req_priv_i             = 2'b00;
    req_valid_i            = 2'b01;
    for (int k = 0; k < 2; k++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (req_ready_o !== 2'b01 && cnt < 10);
      rsp_q.push_back(rsp_t'{1'b0, 64'h0, 1'b1});
      vectors++;
      if (cnt !== (k == 0 ? 1 : 2)) begin
        miscompares++;
        $display("FAIL b2b_illegal_spacing%0d: got %0d cycles, required %0d", k, cnt, (k == 0 ? 1 : 2));
      end
    end
    @(posedge clk); #1;
    req_valid_i = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    bad_addr = 12'h7C5;
    csr_rdata_i = '0; csr_rerr_i = 1'b0;
    reset = 1'b1; flush_i = 1'b0; req_valid_i = 2'b00;
    fork
      responder();
      monitor();
    join_none
    test_reset();
    test_arbitration();
    test_csrrs();
    test_priv();
    test_readonly();
    test_rerr();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(negedge clk);
    vectors++;
    if (rsp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rsp_drain: got %0d responses outstanding, required 0", rsp_q.size());
    end
    vectors++;
    if (wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL write_drain: got %0d writes outstanding, required 0", wr_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
